// File: rtl/regfile_param.sv
// regfile_param: parametrised two-read/one-write register file with an
// optional hardwired zero entry, optional write-to-read bypass, and a
// bulk-clear engine that wipes one entry per cycle without a reset.
//
//   state | meaning
//   IDLE  | normal operation; writes accepted, clear_req sampled
//   CLEAR | wiping entry[ptr] each cycle; writes dropped and flagged
module regfile_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] out_rd,
  output logic [WIDTH-1:0] out_rs,
  input  logic             clear_req,
  output logic             busy,
  output logic             clear_done,
  output logic             wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_nx;
  logic             done_nx;
  logic             wr_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  // A write lands only when the clear engine is idle and it does not target
  // the hardwired zero entry; a zero-entry write is dropped without a flag.
  assign wr_ok = reg_write && !busy && !((ZERO_REG != 0) && (rd == '0));

  // Next-state logic for the clear sequencer; the pointer wraps to 0 on its own.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      CLEAR: begin
        ptr_nx = ptr + AW'(1);
        if (ptr == LAST) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  // Sequencer registers and the registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      wr_drop    <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      busy       <= (state_nx == CLEAR);
      clear_done <= done_nx;
      wr_drop    <= reg_write && busy;
    end
  end

  // Storage array: cleared by reset or by the engine; a write and an engine
  // clear can never coincide because writes need busy low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end
      if (wr_ok) begin
        mem[rd] <= data_in;
      end
    end
  end

  // First read port; it shares its address with the write port.
  always_comb begin
    out_rd = mem[rd];
    if ((BYPASS != 0) && wr_ok) begin
      out_rd = data_in;
    end
    if ((ZERO_REG != 0) && (rd == '0)) begin
      out_rd = '0;
    end
  end

  // Second read port, bypassing only when it matches the accepted write.
  always_comb begin
    out_rs = mem[rs];
    if ((BYPASS != 0) && wr_ok && (rs == rd)) begin
      out_rs = data_in;
    end
    if ((ZERO_REG != 0) && (rs == '0)) begin
      out_rs = '0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three 8x8 variants (bypass, no bypass, zero
// register) share one stimulus stream and are each compared to a reference
// model; a 16x32 variant is exercised for clear length.
module tb_regfile_param;

  logic       clk;
  logic       reset;
  logic       we_s;
  logic [2:0] rd_s;
  logic [2:0] rs_s;
  logic [7:0] din_s;
  logic       clr_s;

  logic [7:0] o_rd   [3];
  logic [7:0] o_rs   [3];
  logic       o_busy [3];
  logic       o_done [3];
  logic       o_drop [3];

  logic        we3;
  logic [4:0]  rd3;
  logic [4:0]  rs3;
  logic [15:0] din3;
  logic        clr3;
  logic [15:0] o_rd3;
  logic [15:0] o_rs3;
  logic        busy3;
  logic        done3;
  logic        drop3;

  int checks = 0;
  int errors = 0;

  regfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk(clk), .reset(reset), .reg_write(we_s), .rd(rd_s), .rs(rs_s),
    .data_in(din_s), .out_rd(o_rd[0]), .out_rs(o_rs[0]), .clear_req(clr_s),
    .busy(o_busy[0]), .clear_done(o_done[0]), .wr_drop(o_drop[0]));

  regfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .reset(reset), .reg_write(we_s), .rd(rd_s), .rs(rs_s),
    .data_in(din_s), .out_rd(o_rd[1]), .out_rs(o_rs[1]), .clear_req(clr_s),
    .busy(o_busy[1]), .clear_done(o_done[1]), .wr_drop(o_drop[1]));

  regfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u2 (
    .clk(clk), .reset(reset), .reg_write(we_s), .rd(rd_s), .rs(rs_s),
    .data_in(din_s), .out_rd(o_rd[2]), .out_rs(o_rs[2]), .clear_req(clr_s),
    .busy(o_busy[2]), .clear_done(o_done[2]), .wr_drop(o_drop[2]));

  regfile_param #(.WIDTH(16), .DEPTH(32), .ZERO_REG(0), .BYPASS(1)) u3 (
    .clk(clk), .reset(reset), .reg_write(we3), .rd(rd3), .rs(rs3),
    .data_in(din3), .out_rd(o_rd3), .out_rs(o_rs3), .clear_req(clr3),
    .busy(busy3), .clear_done(done3), .wr_drop(drop3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase counts cycles since a clear began (0 = idle);
  // during phase p the entry p-1 is wiped at the closing edge.
  logic [7:0] m_mem [3][8];
  int         m_phase [3];
  bit         m_done [3];
  bit         m_drop [3];
  bit         m_byp  [3] = '{1'b1, 1'b0, 1'b1};
  bit         m_zero [3] = '{1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_accept(int i);
    return we_s && (m_phase[i] == 0) && !(m_zero[i] && rd_s == 3'd0);
  endfunction

  function automatic logic [7:0] m_read(int i, logic [2:0] a);
    if (m_zero[i] && a == 3'd0) return 8'h00;
    if (m_byp[i] && m_accept(i) && rd_s == a) return din_s;
    return m_mem[i][a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) m_mem[i][k] = 8'h00;
      m_phase[i] = 0;
      m_done[i]  = 1'b0;
      m_drop[i]  = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      bit acc;
      bit nd;
      bit np;
      acc = m_accept(i);
      nd  = (m_phase[i] == 8);
      np  = we_s && (m_phase[i] != 0);
      if (acc) m_mem[i][rd_s] = din_s;
      if (m_phase[i] != 0) m_mem[i][m_phase[i] - 1] = 8'h00;
      if (m_phase[i] == 0) m_phase[i] = clr_s ? 1 : 0;
      else m_phase[i] = (m_phase[i] == 8) ? 0 : m_phase[i] + 1;
      m_done[i] = nd;
      m_drop[i] = np;
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.out_rd", i), o_rd[i], m_read(i, rd_s));
      chk($sformatf("u%0d.out_rs", i), o_rs[i], m_read(i, rs_s));
      chk($sformatf("u%0d.busy", i), o_busy[i], m_phase[i] != 0);
      chk($sformatf("u%0d.clear_done", i), o_done[i], m_done[i]);
      chk($sformatf("u%0d.wr_drop", i), o_drop[i], m_drop[i]);
    end
  endtask

  // Apply inputs just after the falling edge, then compare against the model.
  task automatic drive(input logic w, input logic [2:0] r, input logic [2:0] s,
                       input logic [7:0] d, input logic c);
    we_s = w; rd_s = r; rs_s = s; din_s = d; clr_s = c;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic       w;
    logic [2:0] r;
    logic [2:0] s;
    logic [7:0] d;
    logic       c;
    logic [7:0] erd;
    logic [7:0] ers;
    logic       eb;
    logic       ed;
    logic       ep;
  } vec_t;

  vec_t tv [15];

  initial begin
    int cnt;

    tv[0]  = '{1'b1, 3'd3, 3'd0, 8'hA5, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 3'd5, 3'd3, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 3'd2, 3'd2, 8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 3'd2, 3'd3, 8'h00, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 3'd6, 3'd6, 8'h77, 1'b1, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 3'd6, 3'd0, 8'h00, 1'b1, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 3'd6, 3'd3, 8'hFF, 1'b0, 8'h77, 8'hA5, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 3'd6, 3'd3, 8'h00, 1'b0, 8'h77, 8'hA5, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 3'd2, 3'd3, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 3'd6, 3'd3, 8'h00, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 3'd6, 3'd2, 8'h00, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 3'd6, 3'd7, 8'h00, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b0, 3'd6, 3'd7, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[13] = '{1'b1, 3'd1, 3'd1, 8'h5A, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0};
    tv[14] = '{1'b0, 3'd1, 3'd6, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    we_s = 1'b0; rd_s = 3'd0; rs_s = 3'd0; din_s = 8'h00; clr_s = 1'b0;
    we3 = 1'b0; rd3 = 5'd0; rs3 = 5'd0; din3 = 16'h0000; clr3 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d.busy", i), o_busy[i], 1'b0);
      chk($sformatf("reset u%0d.out_rd", i), o_rd[i], 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed table on the default variant, others tracked by the model.
    for (int n = 0; n < 15; n++) begin
      drive(tv[n].w, tv[n].r, tv[n].s, tv[n].d, tv[n].c);
      chk($sformatf("tv%0d out_rd", n), o_rd[0], tv[n].erd);
      chk($sformatf("tv%0d out_rs", n), o_rs[0], tv[n].ers);
      chk($sformatf("tv%0d busy", n), o_busy[0], tv[n].eb);
      chk($sformatf("tv%0d clear_done", n), o_done[0], tv[n].ed);
      chk($sformatf("tv%0d wr_drop", n), o_drop[0], tv[n].ep);
      tick();
    end

    // Reset asserted asynchronously three cycles into a clear.
    drive(1'b1, 3'd5, 3'd0, 8'hC3, 1'b0); tick();
    drive(1'b1, 3'd4, 3'd0, 8'hE1, 1'b0); tick();
    drive(1'b0, 3'd0, 3'd0, 8'h00, 1'b1); tick();
    drive(1'b0, 3'd0, 3'd0, 8'h00, 1'b0); tick();
    drive(1'b0, 3'd0, 3'd0, 8'h00, 1'b0); tick();
    drive(1'b0, 3'd5, 3'd4, 8'h00, 1'b0);
    chk("midclear pre busy", o_busy[0], 1'b1);
    chk("midclear pre entry5", o_rd[0], 8'hC3);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midclear busy", o_busy[0], 1'b0);
    chk("midclear busy u3x", o_busy[2], 1'b0);
    chk("midclear entry5", o_rd[0], 8'h00);
    chk("midclear entry4", o_rs[0], 8'h00);
    chk("midclear done", o_done[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      drive(1'b0, 3'(n), 3'(n + 1), 8'h00, 1'b0);
      chk("post-abort clear_done", o_done[0], 1'b0);
      tick();
    end

    // Bypass versus no bypass on a same-cycle write and read.
    drive(1'b1, 3'd2, 3'd2, 8'h3C, 1'b0);
    chk("bypass on out_rs", o_rs[0], 8'h3C);
    chk("bypass off out_rs", o_rs[1], 8'h00);
    chk("bypass off out_rd", o_rd[1], 8'h00);
    tick();
    drive(1'b0, 3'd2, 3'd2, 8'h00, 1'b0);
    chk("bypass off next out_rs", o_rs[1], 8'h3C);
    tick();

    // Hardwired zero entry.
    drive(1'b1, 3'd0, 3'd0, 8'hFF, 1'b0);
    chk("zero same-cycle out_rd", o_rd[2], 8'h00);
    tick();
    drive(1'b1, 3'd1, 3'd0, 8'h42, 1'b0);
    chk("zero out_rs", o_rs[2], 8'h00);
    chk("zero wr_drop", o_drop[2], 1'b0);
    chk("nonzero variant entry0", o_rs[0], 8'hFF);
    tick();
    drive(1'b0, 3'd1, 3'd0, 8'h00, 1'b0);
    chk("zero variant entry1", o_rd[2], 8'h42);
    tick();

    // Fill all entries, then clear with a dropped write in the middle.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 3'(k), 8'((k + 1) * 8'h11), 1'b0);
      tick();
    end
    for (int c = 0; c <= 10; c++) begin
      drive(c == 4, (c == 4) ? 3'd7 : 3'(c), 3'd7, 8'h99, (c == 0) || (c == 6));
      chk($sformatf("fill-clear busy c%0d", c), o_busy[0], (c >= 1) && (c <= 8));
      chk($sformatf("fill-clear done c%0d", c), o_done[0], c == 9);
      chk($sformatf("fill-clear drop c%0d", c), o_drop[0], c == 5);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 3'(k), 3'(7 - k), 8'h00, 1'b0);
      chk($sformatf("cleared entry %0d", k), o_rd[0], 8'h00);
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            8'($urandom), $urandom_range(0, 11) == 0);
      tick();
    end
    drive(1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    for (int n = 0; n < 10; n++) tick();

    // Wide and deep variant: clear must stay busy for exactly DEPTH cycles.
    we3 = 1'b1; rd3 = 5'd31; din3 = 16'hBEEF;
    tick();
    we3 = 1'b0; rs3 = 5'd31;
    #1;
    chk("u3 entry31 write", o_rs3, 16'hBEEF);
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!busy3) break;
      if (done3) chk("u3 done during busy", done3, 1'b0);
      cnt++;
      tick();
    end
    chk("u3 busy cycles", cnt, 32);
    chk("u3 clear_done", done3, 1'b1);
    chk("u3 entry31 cleared", o_rs3, 16'h0000);
    tick();
    #1;
    chk("u3 clear_done pulse width", done3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the team's fixed 8x8 two-read/one-write register file, used as the datapath operand store in the program cores. It adds configurable width and depth, an optional hardwired zero register, optional same-cycle write-to-read bypass, and a sequenced bulk-clear engine that wipes the array one entry per cycle without requiring a reset.

## Interface
Parameters:
- WIDTH, 8, data width of each entry.
- DEPTH, 8, number of entries; must be a power of two, at least 2. AW = $clog2(DEPTH), derived, not overridable.
- ZERO_REG, 0, when 1 entry 0 always reads zero and writes to it are discarded.
- BYPASS, 1, when 1 a read of the address written in the same cycle returns data_in.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- reg_write  in  1  write enable for entry rd.
- rd  in  AW  write address and first read address.
- rs  in  AW  second read address.
- data_in  in  WIDTH  write data.
- out_rd  out  WIDTH  combinational read of entry rd.
- out_rs  out  WIDTH  combinational read of entry rs.
- clear_req  in  1  request a bulk clear; sampled only in IDLE.
- busy  out  1  registered; high while the clear engine runs.
- clear_done  out  1  registered one-cycle pulse when the clear completes.
- wr_drop  out  1  registered one-cycle pulse flagging a write discarded because busy was high.

## Operation
- Reset (async assert): all entries to 0, state IDLE, clear pointer 0, busy/clear_done/wr_drop 0. Outputs out_rd/out_rs therefore read 0.
- Write accepted when reg_write=1 and busy=0: entry rd <= data_in on rising edge. Exception: ZERO_REG=1 and rd=0, discarded silently (no wr_drop).
- Write while busy=1: discarded; wr_drop=1 in the following cycle.
- Reads: out_x = stored entry. If BYPASS=1 and an accepted write targets the same address this cycle, out_x = data_in. ZERO_REG=1 and address 0: out_x = 0 regardless of bypass.
- FSM states IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req=1; pointer loads 0. A write accepted in that same cycle is performed (and later cleared).
  - CLEAR: each cycle entry[pointer] <= 0, pointer increments. When pointer = DEPTH-1, that entry is cleared, state -> IDLE, pointer -> 0.
  - clear_req while in CLEAR ignored (no queuing).
- Reads during CLEAR return current contents (mix of cleared and not-yet-cleared entries); no bypass, as no writes are accepted.
- Pointer width AW; wraps DEPTH-1 -> 0 naturally, no overflow state.

## Timing
- Read latency: 0 cycles (combinational from address/array, plus data_in when bypassing).
- Write latency: 1 cycle; visible on non-bypass read the cycle after the edge.
- clear_req high in cycle N (IDLE): busy=1 in cycles N+1 .. N+DEPTH; entry k zeroed at the edge closing cycle N+1+k; busy=0 and clear_done=1 in cycle N+DEPTH+1 only.
- Earliest new clear: clear_req in cycle N+DEPTH+1 (state IDLE), giving back-to-back clears with one idle cycle.
- A write in cycle N+DEPTH+1 is accepted.
- Reset mid-clear: immediate return to IDLE, array zeroed, busy and clear_done low; no clear_done pulse issued for the aborted clear.

## Test plan
- Reset then write rd=3 data 0xA5, next cycle rs=3 -> out_rs=0xA5; out_rd at rd=5 -> 0x00.
- BYPASS=1: reg_write rd=2 data 0x3C with rs=2 same cycle -> out_rs=0x3C and out_rd=0x3C that cycle; BYPASS=0 same stimulus -> 0x00 that cycle, 0x3C next cycle.
- ZERO_REG=1: write 0xFF to rd=0 -> out_rd at 0 stays 0x00, wr_drop stays 0; write to rd=1 works normally.
- Fill all 8 entries with 0x11..0x88, pulse clear_req in cycle N -> busy high N+1..N+8, clear_done high only in N+9, all entries 0x00; write in N+4 to rd=7 -> wr_drop=1 in N+5, entry 7 reads 0x00 after clear.
- Clear_req at N with simultaneous write rd=6 data 0x77 -> entry 6 reads 0x77 during N+1..N+6, 0x00 from N+8; second clear_req during busy ignored (busy drops at N+9).
- Assert reset asynchronously at N+3 of a clear -> busy=0 immediately, no clear_done pulse, all reads 0x00; WIDTH=16, DEPTH=32 instance: clear busy for exactly 32 cycles.
